// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding,
// default sizing and a width helper usable in constant expressions.
package uart_pkg;

    localparam int N_DEF  = 4;
    localparam int W_DEF  = 8;
    localparam int WD_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request at or after ptr wins,
// wrapping modulo N so non-power-of-2 requester counts work.
module rr_pick
    import uart_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] win_id
);

    always_comb begin
        int idx;
        valid  = |req;
        win_id = '0;
        idx    = 0;
        // Walk the rotation backwards so the earliest position wins.
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                win_id = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sequencing one UART transmitter among N requesters,
// with a watchdog on the transmitter's response to load.
module tx_arbiter
    import uart_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int W  = W_DEF,
    parameter int WD = WD_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req,
    input  logic [N*W-1:0]        data,
    input  logic                  tx_ready,
    output logic [N-1:0]          ack,
    output logic                  load,
    output logic [W-1:0]          tx_data,
    output logic [clog2(N)-1:0]   gnt_id,
    output logic                  busy,
    output logic                  err
);

    localparam int IW = clog2(N);
    localparam int CW = clog2(WD + 1);

    state_t         state_q, state_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [IW-1:0]  gnt_q, gnt_d;
    logic [W-1:0]   tx_data_q, tx_data_d;
    logic           err_q, err_d;
    logic           load_q, load_d;
    logic [N-1:0]   ack_q, ack_d;
    logic [CW-1:0]  wd_q, wd_d;

    logic           pick_valid;
    logic [IW-1:0]  pick_id;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .valid  (pick_valid),
        .win_id (pick_id)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        tx_data_d = tx_data_q;
        err_d     = err_q;
        wd_d      = wd_q;
        load_d    = 1'b0;
        ack_d     = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (tx_ready && pick_valid) begin
                    tx_data_d = data[int'(pick_id)*W +: W];
                    gnt_d     = pick_id;
                    load_d    = 1'b1;
                    ack_d     = N'(1) << pick_id;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (gnt_q == IW'(N - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = gnt_q + 1'b1;
                end
                wd_d    = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!tx_ready) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    if (wd_q < CW'(WD)) begin
                        wd_d = wd_q + 1'b1;
                    end
                    // WD-th consecutive ready cycle: give up, frame assumed gone.
                    if (wd_q >= CW'(WD - 1)) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (tx_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            tx_data_q <= '0;
            err_q     <= 1'b0;
            load_q    <= 1'b0;
            ack_q     <= '0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            tx_data_q <= tx_data_d;
            err_q     <= err_d;
            load_q    <= load_d;
            ack_q     <= ack_d;
            wd_q      <= wd_d;
        end
    end

    assign ack     = ack_q;
    assign load    = load_q;
    assign tx_data = tx_data_q;
    assign gnt_id  = gnt_q;
    assign busy    = (state_q != ST_IDLE);
    assign err     = err_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: reset, single grant, rotation,
// contention, not-ready stall, mid-frame reset and watchdog.
module tb_tx_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int WD = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N*W-1:0] data;
    logic         tx_ready;
    logic [N-1:0] ack;
    logic         load;
    logic [W-1:0] tx_data;
    logic [1:0]   gnt_id;
    logic         busy;
    logic         err;

    int tests = 0;
    int fails = 0;

    tx_arbiter #(.N(N), .W(W), .WD(WD)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .data     (data),
        .tx_ready (tx_ready),
        .ack      (ack),
        .load     (load),
        .tx_data  (tx_data),
        .gnt_id   (gnt_id),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_load(input string tag);
        int n;
        n = 0;
        tick();
        while (!load && n < 30) begin
            tick();
            n++;
        end
        chk({tag, "_load"}, 32'(load), 32'd1);
    endtask

    // Transmitter model: busy for three sampled cycles after load.
    task automatic xmit(input string tag);
        tx_ready = 1'b0;
        tick();
        chk({tag, "_load_pulse"}, 32'(load), 32'd0);
        chk({tag, "_ack_pulse"}, 32'(ack), 32'd0);
        tick();
        tick();
        tx_ready = 1'b1;
    endtask

    task automatic frame(input string tag, input int id,
                         input logic [7:0] b);
        wait_load(tag);
        chk({tag, "_ack"}, 32'(ack), 32'(1 << id));
        chk({tag, "_gnt"}, 32'(gnt_id), 32'(id));
        chk({tag, "_data"}, 32'(tx_data), 32'(b));
        xmit(tag);
    endtask

    initial begin
        logic seen;
        rst      = 1'b1;
        req      = '0;
        data     = {8'h44, 8'h33, 8'h22, 8'h11};
        tx_ready = 1'b0;
        tick();
        tick();
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_load", 32'(load), 32'd0);
        chk("rst_txdata", 32'(tx_data), 32'd0);
        chk("rst_gnt", 32'(gnt_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // Single request, one-cycle latency
        rst      = 1'b0;
        data     = {8'h44, 8'h33, 8'hA5, 8'h11};
        tx_ready = 1'b1;
        req      = 4'b0010;
        tick();
        chk("single_load", 32'(load), 32'd1);
        chk("single_ack", 32'(ack), 32'b0010);
        chk("single_data", 32'(tx_data), 32'hA5);
        chk("single_gnt", 32'(gnt_id), 32'd1);
        chk("single_busy", 32'(busy), 32'd1);
        req = '0;
        xmit("single");
        tick();
        chk("single_idle", 32'(busy), 32'd0);

        // Pointer now 2: req 0011 wraps to 0, then 1
        data = {8'h44, 8'h33, 8'h22, 8'h11};
        req  = 4'b0011;
        frame("skip0", 0, 8'h11);
        frame("skip1", 1, 8'h22);
        req = '0;
        tick();
        tick();

        // Reset in WAIT_DONE
        req = 4'b0010;
        wait_load("midrst");
        chk("midrst_gnt", 32'(gnt_id), 32'd1);
        req      = '0;
        tx_ready = 1'b0;
        tick();
        tick();
        chk("midrst_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_gnt0", 32'(gnt_id), 32'd0);
        chk("midrst_data0", 32'(tx_data), 32'd0);
        tx_ready = 1'b1;

        // Full contention from ptr 0
        req = 4'b1111;
        frame("cont0", 0, 8'h11);
        frame("cont1", 1, 8'h22);
        frame("cont2", 2, 8'h33);
        frame("cont3", 3, 8'h44);
        frame("cont4", 0, 8'h11);
        req = 4'b0100;
        frame("post_rst", 2, 8'h33);
        req = '0;
        tick();
        tick();

        // Transmitter not ready
        tx_ready = 1'b0;
        req      = 4'b0001;
        seen     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen = seen | load;
        end
        chk("notready_noload", 32'(seen), 32'd0);
        tx_ready = 1'b1;
        tick();
        chk("notready_load", 32'(load), 32'd1);
        chk("notready_ack", 32'(ack), 32'b0001);

        // Watchdog: transmitter never drops ready
        req = '0;
        tick();
        tick();
        tick();
        tick();
        chk("wd_err_early", 32'(err), 32'd0);
        chk("wd_busy_early", 32'(busy), 32'd1);
        tick();
        chk("wd_err", 32'(err), 32'd1);
        chk("wd_idle", 32'(busy), 32'd0);
        req = 4'b0010;
        frame("wd_next", 1, 8'h22);
        req = '0;
        tick();
        tick();
        chk("wd_sticky", 32'(err), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("wd_clear", 32'(err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tx_arbiter.md
# tx_arbiter

Round-robin arbiter that shares the single UART transmitter between `N` byte-producing requesters. It sits between the requesters and the transmit controller and sequences the transmitter's load handshake so that exactly one frame is in flight at a time. It also keeps grants fair, and flags a transmitter that fails to acknowledge a load. It is the transmit-side counterpart of the receive controller and runs on the same clock and reset.

## Interface
Parameters:
- `N`, 4, number of requesters (2..8)
- `W`, 8, data width per requester
- `WD`, 4, watchdog limit in cycles for `tx_ready` to drop after `load`

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req`  in  N  per-requester request level; held until acked
- `data`  in  N*W  requester i's byte on bits [i*W +: W]
- `tx_ready`  in  1  transmitter idle/able to accept a byte
- `ack`  out  N  one-hot, one-cycle pulse: requester's byte has been captured
- `load`  out  1  one-cycle pulse to transmitter: accept `tx_data`
- `tx_data`  out  W  byte for the transmitter, stable from `load` until the next grant
- `gnt_id`  out  clog2(N)  index of the current/last granted requester
- `busy`  out  1  high in every state except IDLE
- `err`  out  1  sticky watchdog flag; cleared only by `rst`

## Operation
- FSM states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
- **IDLE**
  - If `tx_ready`=1 and `req`≠0: pick winner `w`, latch `data[w]` into `tx_data`, set `gnt_id`=w, and go to LOAD.
  - Otherwise stay in IDLE.
- **LOAD** (exactly one cycle)
  - Assert `load`=1 and `ack[w]`=1.
  - Update pointer: `ptr`=(w+1) mod N.
  - Go to WAIT_BUSY.
- **WAIT_BUSY**
  - When `tx_ready`=0, go to WAIT_DONE.
  - If `tx_ready` stays 1 for `WD` consecutive cycles, set `err`=1 and go to IDLE (frame assumed consumed).
- **WAIT_DONE**
  - When `tx_ready`=1, go to IDLE. No timeout: frame length depends on baud.
- **Winner selection**
  - Scan the rotated order `ptr`, ptr+1, …, ptr+N-1 (mod N); the first set `req` bit wins.
  - Simultaneous requests resolve strictly by that rotation.
- **Request sampling**
  - `req` is sampled only in IDLE. Changes to `req`/`data` in other states are ignored.
  - A requester dropping `req` after being selected still gets its latched byte sent.
- **Reset**
  - On `rst`=1 (any state, including mid-frame): go to IDLE; `ptr`=0, `tx_data`=0, `gnt_id`=0, `err`=0.
  - All pulses (`load`, `ack`) are 0 and `busy`=0 on the next edge.
  - A frame already started in the transmitter is not recalled.
- **Width rules**
  - `ptr` and `gnt_id` are clog2(N) bits; wrap uses modulo N, which must hold for non-power-of-2 N.
  - The watchdog counter is clog2(WD+1) bits and saturates.

## Timing
- **Reset values:** `ack`=0, `load`=0, `tx_data`=0, `gnt_id`=0, `busy`=0, `err`=0.
- **Request-to-load latency:** with `tx_ready`=1, `req` sampled high at edge k gives `load`/`ack` high during cycle k+1.
- **Back-to-back throughput:** minimum 4 cycles between successive `load` pulses (LOAD, WAIT_BUSY, WAIT_DONE, IDLE), plus the frame time.
- **Data stability:** `tx_data` changes only on the IDLE→LOAD edge.
- **Output style:** all outputs are registered or decoded from state registers only; no combinational path from `req` to `load`/`ack`.

## Structure
- **Shared package `uart_pkg`:**
  - state encoding for IDLE/LOAD/WAIT_BUSY/WAIT_DONE (2-bit)
  - default `N`, `W`, `WD`
  - clog2 helper function
- **Sub-module `rr_pick`:** combinational rotating priority picker.
  - Inputs: `req[N-1:0]`, `ptr`.
  - Outputs: `valid`, `win_id`.
  - Unit-testable on its own.
- **Top level:** FSM, data latch, pointer and watchdog.

## Test plan
- **Reset mid-frame:** assert `rst` during WAIT_DONE → next cycle `busy`=0, `ptr`=0, `err`=0; a subsequent `req`=0b0100 is granted `gnt_id`=2.
- **Single request:** `req`=0b0010, `data[1]`=8'hA5, `tx_ready`=1 → `load`=1 and `ack`=0b0010 one cycle later; `tx_data`=8'hA5, `gnt_id`=1.
- **Full contention, N=4:** hold `req`=0b1111 and model the transmitter as 3 cycles busy → grant order 0,1,2,3,0; each `ack` is a single pulse.
- **Pointer skip:** `ptr`=2, `req`=0b0011 → grant 0; next grant with `req`=0b0011 → grant 1.
- **Transmitter not ready:** `req`=0b0001 with `tx_ready`=0 for 20 cycles → no `load`; `load` is issued one cycle after `tx_ready` rises.
- **Watchdog:** after `load`, hold `tx_ready`=1 → `err`=1 after `WD`=4 cycles, FSM back in IDLE; `err` persists through further grants until `rst`.
